// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: shares one ALU and one memory port across
// fetch, execute and data access by stepping the control bundle through an FSM.

package multicycle_control_pkg;

   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'd0,
      ALUOP_FUNCT  = 2'd1,
      ALUOP_BRANCH = 2'd2
   } aluop_t;

   localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE   = 7'b0010011;
   localparam logic [6:0] OPC_ITYPE_L = 7'b0000011;
   localparam logic [6:0] OPC_STYPE   = 7'b0100011;
   localparam logic [6:0] OPC_BTYPE   = 7'b1100011;
   localparam logic [6:0] OPC_JTYPE   = 7'b1101111;
   localparam logic [6:0] OPC_ITYPE_J = 7'b1100111;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;

   localparam logic [1:0] CTL_PCSEL_PCPLUS4   = 2'd0;
   localparam logic [1:0] CTL_PCSEL_PCPLUSIMM = 2'd1;
   localparam logic [1:0] CTL_PCSEL_RPLUSIMM  = 2'd2;

   localparam logic [2:0] CTL_WB_ALU = 3'd0;
   localparam logic [2:0] CTL_WB_MEM = 3'd1;
   localparam logic [2:0] CTL_WB_PC4 = 3'd2;
   localparam logic [2:0] CTL_WB_IMM = 3'd3;

endpackage

module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] inst_opc,
   input  logic       take_branch,
   input  logic       mem_ready,
   output logic       CTL_PcWrite,
   output logic       CTL_IrWrite,
   output logic       CTL_IorD,
   output logic       CTL_RegWrite,
   output aluop_t     CTL_AluOp,
   output logic       CTL_AluSrc,
   output logic [1:0] CTL_PcSel,
   output logic       CTL_MemRead,
   output logic       CTL_MemWrite,
   output logic [2:0] CTL_MemToReg,
   output logic [2:0] state_o,
   output logic       trap_o
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;

   logic       pc_write, ir_write, ior_d, reg_write, alu_src, mem_read, mem_write, trap;
   aluop_t     alu_op;
   logic [1:0] pc_sel;
   logic [2:0] mem_to_reg;

   logic is_rtype, is_itype, is_load, is_store, is_btype, is_jal, is_jalr, is_lui, is_auipc;
   logic is_legal, timeout;

   assign is_rtype = (inst_opc == OPC_RTYPE);
   assign is_itype = (inst_opc == OPC_ITYPE);
   assign is_load  = (inst_opc == OPC_ITYPE_L);
   assign is_store = (inst_opc == OPC_STYPE);
   assign is_btype = (inst_opc == OPC_BTYPE);
   assign is_jal   = (inst_opc == OPC_JTYPE);
   assign is_jalr  = (inst_opc == OPC_ITYPE_J);
   assign is_lui   = (inst_opc == OPC_LUI);
   assign is_auipc = (inst_opc == OPC_AUIPC);
   assign is_legal = is_rtype | is_itype | is_load | is_store | is_btype |
                     is_jal | is_jalr | is_lui | is_auipc;
   assign timeout  = (wait_q == CNT_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state and control decode; the IR holds inst_opc stable after FETCH.
   always_comb begin
      state_d    = state_q;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      ior_d      = 1'b0;
      reg_write  = 1'b0;
      alu_op     = ALUOP_ADD;
      alu_src    = 1'b0;
      pc_sel     = CTL_PCSEL_PCPLUS4;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = CTL_WB_ALU;
      trap       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d  = S_TRAP;
            end
         end
         S_DECODE: state_d = is_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_rtype) begin
               alu_op  = ALUOP_FUNCT;
               state_d = S_WB;
            end else if (is_itype) begin
               alu_op  = ALUOP_FUNCT;
               alu_src = 1'b1;
               state_d = S_WB;
            end else if (is_lui || is_auipc) begin
               alu_src = 1'b1;
               state_d = S_WB;
            end else if (is_load || is_store) begin
               alu_src = 1'b1;
               state_d = S_MEM;
            end else if (is_btype) begin
               alu_op   = ALUOP_BRANCH;
               pc_write = 1'b1;
               pc_sel   = take_branch ? CTL_PCSEL_PCPLUSIMM : CTL_PCSEL_PCPLUS4;
               state_d  = S_FETCH;
            end else if (is_jal || is_jalr) begin
               reg_write  = 1'b1;
               mem_to_reg = CTL_WB_PC4;
               pc_write   = 1'b1;
               pc_sel     = is_jal ? CTL_PCSEL_PCPLUSIMM : CTL_PCSEL_RPLUSIMM;
               state_d    = S_FETCH;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_MEM: begin
            ior_d     = 1'b1;
            mem_read  = is_load;
            mem_write = ~is_load;
            if (mem_ready) begin
               if (is_load) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
            end else if (timeout) begin
               state_d = S_TRAP;
            end
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (is_load) begin
               mem_to_reg = CTL_WB_MEM;
            end else if (is_lui) begin
               mem_to_reg = CTL_WB_IMM;
            end
            state_d = S_FETCH;
         end
         S_TRAP:  trap = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end

   // Wait counter: restarts on every transition, counts unanswered request cycles.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) begin
         wait_d = '0;
      end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && wait_q != CNT_MAX) begin
         wait_d = wait_q + CNT_W'(1);
      end
   end

   assign CTL_PcWrite  = pc_write  & ~rst;
   assign CTL_IrWrite  = ir_write  & ~rst;
   assign CTL_IorD     = ior_d     & ~rst;
   assign CTL_RegWrite = reg_write & ~rst;
   assign CTL_AluOp    = rst ? ALUOP_ADD : alu_op;
   assign CTL_AluSrc   = alu_src   & ~rst;
   assign CTL_PcSel    = rst ? CTL_PCSEL_PCPLUS4 : pc_sel;
   assign CTL_MemRead  = mem_read  & ~rst;
   assign CTL_MemWrite = mem_write & ~rst;
   assign CTL_MemToReg = rst ? CTL_WB_ALU : mem_to_reg;
   assign trap_o       = trap      & ~rst;
   assign state_o      = rst ? 3'd0 : 3'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-level scoreboard bench for multicycle_control: expected per-cycle state
// and control bundle are queued with the stimulus, then compared cycle by cycle.

module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] inst_opc = OPC_RTYPE;
   logic       take_branch = 1'b0;
   logic       mem_ready = 1'b0;
   logic       CTL_PcWrite, CTL_IrWrite, CTL_IorD, CTL_RegWrite, CTL_AluSrc;
   aluop_t     CTL_AluOp;
   logic [1:0] CTL_PcSel;
   logic       CTL_MemRead, CTL_MemWrite;
   logic [2:0] CTL_MemToReg, state_o;
   logic       trap_o;

   always #5 clk = ~clk;

   multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .inst_opc(inst_opc), .take_branch(take_branch),
      .mem_ready(mem_ready), .CTL_PcWrite(CTL_PcWrite), .CTL_IrWrite(CTL_IrWrite),
      .CTL_IorD(CTL_IorD), .CTL_RegWrite(CTL_RegWrite), .CTL_AluOp(CTL_AluOp),
      .CTL_AluSrc(CTL_AluSrc), .CTL_PcSel(CTL_PcSel), .CTL_MemRead(CTL_MemRead),
      .CTL_MemWrite(CTL_MemWrite), .CTL_MemToReg(CTL_MemToReg),
      .state_o(state_o), .trap_o(trap_o)
   );

   typedef struct {
      logic        rst;
      logic        ready;
      logic        br;
      logic [6:0]  opc;
      logic [2:0]  st;
      logic [14:0] ctl;
      string       tag;
   } cyc_t;

   cyc_t sb_q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Bundle order: PcWrite IrWrite IorD RegWrite AluOp[1:0] AluSrc PcSel[1:0] MemRead MemWrite MemToReg[2:0] trap
   function automatic logic [14:0] mk(input logic pcw, input logic irw, input logic iord,
                                      input logic regw, input logic [1:0] aop, input logic asrc,
                                      input logic [1:0] psel, input logic mr, input logic mw,
                                      input logic [2:0] m2r, input logic trp);
      return {pcw, irw, iord, regw, aop, asrc, psel, mr, mw, m2r, trp};
   endfunction

   task automatic push(input logic r, input logic rdy, input logic br, input logic [6:0] opc,
                       input logic [2:0] st, input logic [14:0] c, input string tag);
      cyc_t e;
      e.rst = r; e.ready = rdy; e.br = br; e.opc = opc; e.st = st; e.ctl = c; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic add_reset(input int n);
      for (int i = 0; i < n; i++)
         push(1'b1, 1'(($urandom_range(0, 1))), 1'b0, OPC_RTYPE, 3'd0, 15'd0, "reset");
   endtask

   // Expected sequence for one instruction; mem_abort >= 0 stops after that many MEM wait cycles.
   task automatic add_instr(input logic [6:0] opc, input logic br, input int fw, input int mw,
                            input int mem_abort, input string nm);
      logic ld, st, wb, mem;
      logic [1:0] aop, psel;
      logic asrc, pcw, regw;
      logic [2:0] m2r, nxt;
      ld  = (opc == OPC_ITYPE_L);
      st  = (opc == OPC_STYPE);
      for (int i = 0; i < fw; i++)
         push(1'b0, 1'b0, br, opc, 3'd0, mk(0,0,0,0,2'd0,0,2'd0,1,0,3'd0,0), {nm, ".fetch_wait"});
      push(1'b0, 1'b1, br, opc, 3'd0, mk(0,1,0,0,2'd0,0,2'd0,1,0,3'd0,0), {nm, ".fetch"});
      push(1'b0, 1'b1, br, opc, 3'd1, 15'd0, {nm, ".decode"});
      if (!(opc inside {OPC_RTYPE, OPC_ITYPE, OPC_ITYPE_L, OPC_STYPE, OPC_BTYPE,
                        OPC_JTYPE, OPC_ITYPE_J, OPC_LUI, OPC_AUIPC})) begin
         for (int i = 0; i < 20; i++)
            push(1'b0, 1'(($urandom_range(0, 1))), br, opc, 3'd5, mk(0,0,0,0,2'd0,0,2'd0,0,0,3'd0,1),
                 {nm, ".trap"});
         return;
      end
      aop = 2'(ALUOP_ADD); asrc = 1'b0; pcw = 1'b0; regw = 1'b0; psel = CTL_PCSEL_PCPLUS4;
      m2r = 3'd0; wb = 1'b0; mem = 1'b0;
      case (opc)
         OPC_RTYPE:            begin aop = 2'(ALUOP_FUNCT); wb = 1'b1; end
         OPC_ITYPE:            begin aop = 2'(ALUOP_FUNCT); asrc = 1'b1; wb = 1'b1; end
         OPC_LUI, OPC_AUIPC:   begin asrc = 1'b1; wb = 1'b1; end
         OPC_ITYPE_L, OPC_STYPE: begin asrc = 1'b1; mem = 1'b1; end
         OPC_BTYPE: begin
            aop = 2'(ALUOP_BRANCH); pcw = 1'b1;
            psel = br ? CTL_PCSEL_PCPLUSIMM : CTL_PCSEL_PCPLUS4;
         end
         OPC_JTYPE:   begin regw = 1'b1; m2r = 3'd2; pcw = 1'b1; psel = CTL_PCSEL_PCPLUSIMM; end
         default:     begin regw = 1'b1; m2r = 3'd2; pcw = 1'b1; psel = CTL_PCSEL_RPLUSIMM; end
      endcase
      nxt = 3'd2;
      push(1'b0, 1'b1, br, opc, nxt, mk(pcw,0,0,regw,aop,asrc,psel,0,0,m2r,0), {nm, ".exec"});
      if (mem) begin
         for (int i = 0; i < mw; i++) begin
            if (mem_abort == i) return;
            push(1'b0, 1'b0, br, opc, 3'd3, mk(0,0,1,0,2'd0,0,2'd0,ld,st,3'd0,0), {nm, ".mem_wait"});
         end
         if (mem_abort >= 0) return;
         push(1'b0, 1'b1, br, opc, 3'd3, mk(st,0,1,0,2'd0,0,2'd0,ld,st,3'd0,0), {nm, ".mem"});
         wb = ld;
      end
      if (wb)
         push(1'b0, 1'(($urandom_range(0, 1))), br, opc, 3'd4,
              mk(1,0,0,1,2'd0,0,2'd0,0,0, ld ? 3'd1 : (opc == OPC_LUI ? 3'd3 : 3'd0), 0),
              {nm, ".wb"});
   endtask

   task automatic add_timeout();
      for (int i = 0; i < 5; i++)
         push(1'b0, 1'b0, 1'b0, OPC_RTYPE, 3'd0, mk(0,0,0,0,2'd0,0,2'd0,1,0,3'd0,0), "tmo.fetch");
      for (int i = 0; i < 3; i++)
         push(1'b0, 1'b0, 1'b0, OPC_RTYPE, 3'd5, mk(0,0,0,0,2'd0,0,2'd0,0,0,3'd0,1), "tmo.trap");
   endtask

   logic [6:0] legal_opcs [9];
   logic [6:0] zero_opc;

   initial begin
      cyc_t e;
      legal_opcs = '{OPC_RTYPE, OPC_ITYPE, OPC_ITYPE_L, OPC_STYPE, OPC_BTYPE,
                     OPC_JTYPE, OPC_ITYPE_J, OPC_LUI, OPC_AUIPC};
      zero_opc = 7'b0000000;

      add_reset(2);
      add_instr(OPC_RTYPE,   1'b0, 0, 0, -1, "rtype");
      add_instr(OPC_ITYPE_L, 1'b0, 0, 3, -1, "load_w3");
      add_instr(OPC_BTYPE,   1'b1, 0, 0, -1, "beq_taken");
      add_instr(OPC_BTYPE,   1'b0, 0, 0, -1, "beq_not");
      add_instr(OPC_ITYPE_J, 1'b0, 0, 0, -1, "jalr");
      add_instr(OPC_JTYPE,   1'b1, 1, 0, -1, "jal");
      add_instr(OPC_ITYPE,   1'b0, 2, 0, -1, "itype");
      add_instr(OPC_LUI,     1'b0, 0, 0, -1, "lui");
      add_instr(OPC_AUIPC,   1'b0, 0, 0, -1, "auipc");
      add_instr(OPC_STYPE,   1'b0, 1, 2, -1, "store");
      add_instr(OPC_ITYPE_L, 1'b0, 3, 0, -1, "load_fw3");
      add_instr(zero_opc,    1'b0, 0, 0, -1, "illegal");
      add_reset(1);
      add_instr(OPC_RTYPE,   1'b0, 0, 0, -1, "after_trap");
      add_timeout();
      add_reset(1);
      add_instr(OPC_RTYPE,   1'b0, 4, 0, -1, "ready_at_limit");
      add_instr(OPC_ITYPE_L, 1'b0, 0, 3, 2, "load_abort");
      add_reset(1);
      add_instr(OPC_STYPE,   1'b0, 0, 0, -1, "store_z");
      for (int k = 0; k < 12; k++)
         add_instr(legal_opcs[$urandom_range(0, 8)], 1'(($urandom_range(0, 1))),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1, "rand");

      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         rst         = e.rst;
         mem_ready   = e.ready;
         take_branch = e.br;
         inst_opc    = e.opc;
         @(negedge clk);
         check({e.tag, ".state"}, 32'(state_o), 32'(e.st));
         check({e.tag, ".ctl"},
               32'({CTL_PcWrite, CTL_IrWrite, CTL_IorD, CTL_RegWrite, 2'(CTL_AluOp), CTL_AluSrc,
                    CTL_PcSel, CTL_MemRead, CTL_MemWrite, CTL_MemToReg, trap_o}),
               32'(e.ctl));
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RV32I datapath. It drives the existing CTL_* control bundle from a state machine instead of pure opcode decode, so a single ALU and a single unified memory port can be shared across fetch, execute and data access. It sits between the instruction register and memory handshake on one side and the PC, register file, ALU and memory muxes on the other. Encodings come from `control_bits.scvh`.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a memory request may wait for mem_ready before the FSM traps (1..255).
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- inst_opc  input  7  opcode field of the instruction register
- take_branch  input  1  branch comparator result, valid in EXEC
- mem_ready  input  1  memory completes the current request this cycle
- CTL_PcWrite  output  1  PC register load enable
- CTL_IrWrite  output  1  instruction register load enable
- CTL_IorD  output  1  memory address select: 0 = PC, 1 = ALU result
- CTL_RegWrite  output  1  register file write enable
- CTL_AluOp  output  aluop_t  ALU operation class
- CTL_AluSrc  output  1  ALU operand B select: 0 = rs2, 1 = immediate
- CTL_PcSel  output  2  `CTL_PCSEL_PCPLUS4 / `CTL_PCSEL_PCPLUSIMM / `CTL_PCSEL_RPLUSIMM
- CTL_MemRead  output  1  memory read request
- CTL_MemWrite  output  1  memory write request
- CTL_MemToReg  output  3  writeback select: 0 = ALU, 1 = MEM, 2 = PC+4, 3 = IMM
- state_o  output  3  current state, for debug
- trap_o  output  1  FSM is in TRAP

## Operation
- States and state_o encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are a Moore decode of the state, plus inst_opc and take_branch in EXEC. All strobes are 0 unless listed for the current state.
- FETCH
  - Outputs: CTL_MemRead = 1, CTL_IorD = 0.
  - Stays in FETCH until mem_ready.
  - On mem_ready: CTL_IrWrite = 1 in the same cycle, next state DECODE.
- DECODE (1 cycle)
  - Legal opcodes: `OPC_RTYPE, `OPC_ITYPE, `OPC_ITYPE_L, `OPC_STYPE, `OPC_BTYPE, `OPC_JTYPE, `OPC_ITYPE_J, LUI, AUIPC. These go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC (1 cycle)
  - R-type: AluOp = FUNCT, AluSrc = 0, next WB.
  - I-type, LUI, AUIPC: AluOp = FUNCT or ADD, AluSrc = 1, next WB.
  - Load and store: AluOp = ADD, AluSrc = 1, next MEM.
  - B-type: AluOp = BRANCH, AluSrc = 0, PcWrite = 1, PcSel = take_branch ? PCPLUSIMM : PCPLUS4, next FETCH.
  - JAL: RegWrite = 1, MemToReg = 2, PcWrite = 1, PcSel = PCPLUSIMM, next FETCH.
  - JALR: RegWrite = 1, MemToReg = 2, PcWrite = 1, PcSel = RPLUSIMM, next FETCH.
- MEM
  - Load: CTL_MemRead = 1, CTL_IorD = 1, held until mem_ready.
  - Store: CTL_MemWrite = 1, CTL_IorD = 1, held until mem_ready.
  - On mem_ready, load: next WB.
  - On mem_ready, store: PcWrite = 1, PcSel = PCPLUS4, next FETCH.
- WB (1 cycle)
  - RegWrite = 1, PcWrite = 1, PcSel = PCPLUS4, next FETCH.
  - MemToReg: 1 for loads, 3 for LUI, 0 otherwise.
- TRAP
  - All strobes 0, trap_o = 1.
  - Exits only on rst.
- Wait counter (8 bits)
  - Clears on every state change.
  - Increments each cycle spent in FETCH or MEM without mem_ready; saturates.
  - If the count equals TIMEOUT_CYCLES and mem_ready is still 0, the next state is TRAP.
  - mem_ready in the same cycle wins over the timeout.

## Timing
- Reset:
  - While rst = 1, every CTL_* output and trap_o is forced to 0.
  - The state register loads FETCH on the edge; the wait counter loads 0; state_o reads 0.
  - The first fetch request is issued in the first cycle after rst deasserts.
- Memory handshake:
  - A request asserts from state entry and stays stable until the mem_ready cycle, inclusive.
  - It deasserts in the following cycle.
  - mem_ready outside FETCH or MEM is ignored.
- Cycle counts with zero-wait memory (mem_ready high in the first request cycle):
  - Branch, JAL, JALR: 3 cycles.
  - R-type, I-type, LUI, AUIPC, store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- PC and register writes occur on the clock edge ending the state in which they are asserted. JAL/JALR RegWrite therefore uses the pre-update PC+4.
- Reset mid-operation: a pending request is dropped in the reset cycle with no write strobe, and the FSM restarts at FETCH.

## Test plan
- Reset, zero-wait memory, `OPC_RTYPE:
  - Required state_o sequence: 0, 1, 2, 4, 0.
  - RegWrite = 1 only in WB, with MemToReg = 0.
- Load with mem_ready delayed 3 cycles in MEM:
  - MemRead and IorD = 1 are held for exactly 4 MEM cycles.
  - Then WB with MemToReg = 1; total 8 cycles.
- `OPC_BTYPE:
  - take_branch = 1 gives PcSel = PCPLUSIMM with PcWrite in EXEC.
  - take_branch = 0 gives PCPLUS4.
  - Both return to FETCH in 3 cycles.
- JALR:
  - In EXEC: RegWrite = 1, MemToReg = 2, PcSel = RPLUSIMM, PcWrite = 1.
  - No MEM or WB state is visited.
- Illegal opcode 7'b0000000:
  - DECODE goes to TRAP; trap_o = 1 and all strobes 0 for 20 cycles.
  - rst returns state_o to 0.
- TIMEOUT_CYCLES = 4, mem_ready tied low in FETCH:
  - TRAP is entered after exactly 5 FETCH cycles.
  - Repeat with mem_ready = 1 in the 5th cycle: the FSM goes to DECODE, not TRAP.
